prog_sequencer: RTL and testbench

//  Run controller for the three-program core. Selects one program (PRODUCT,

---
 rtl/prog_sequencer_pkg.sv | 34 +++
 rtl/prog_sequencer_if.sv | 28 ++
 rtl/prog_sequencer_cycle_counter.sv | 27 ++
 rtl/prog_sequencer.sv | 95 +++++++++
 tb/tb_prog_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/prog_sequencer_pkg.sv
// Shared types and constants for the program run controller.
package prog_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_LOAD = 2'd1,
        SEQ_RUN  = 2'd2,
        SEQ_DONE = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        PROD  = 2'd0,
        STRM  = 2'd1,
        CPAIR = 2'd2
    } prog_id_t;

    localparam int          NUM_PROGS = 3;
    localparam logic [7:0]  PROG_START [NUM_PROGS] = '{8'd0, 8'd25, 8'd44};
    localparam logic [3:0]  OP_HALT = 4'hF;

    // Start address lookup; only ever called with a legal program id.
    function automatic logic [7:0] prog_start(input logic [1:0] sel);
        logic [7:0] addr;
        addr = 8'd0;
        case (sel)
            PROD:    addr = PROG_START[0];
            STRM:    addr = PROG_START[1];
            CPAIR:   addr = PROG_START[2];
            default: addr = 8'd0;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// Handshake and status bundle between the bench/host and the run controller.
interface prog_sequencer_if #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic [1:0]       prog_sel;
    logic             halt;
    logic             pc_load;
    logic [PC_W-1:0]  pc_load_addr;
    logic             run;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             err;
    logic [1:0]       prog_id;
    logic [CNT_W-1:0] cycles;

    modport master (
        output start, prog_sel, halt,
        input  pc_load, pc_load_addr, run, busy, done, timeout, err, prog_id, cycles
    );

    modport slave (
        input  start, prog_sel, halt,
        output pc_load, pc_load_addr, run, busy, done, timeout, err, prog_id, cycles
    );
endinterface

// File: rtl/prog_sequencer_cycle_counter.sv
// RUN-cycle counter with synchronous clear and watchdog terminal count.
module seq_cycle_counter #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    // Flags the cycle whose increment lands on TIMEOUT, so the FSM stops
    // on the same edge that the count reaches it.
    assign tc = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller: start/select handshake, PC load, run enable, halt/watchdog stop.
module prog_sequencer
    import prog_sequencer_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 4000
) (
    input  logic           clk,
    input  logic           reset,
    prog_sequencer_if.slave bus
);

    seq_state_t       state;
    logic             pc_load_q, run_q, busy_q, done_q, timeout_q, err_q;
    logic [PC_W-1:0]  addr_q;
    logic [1:0]       prog_id_q;
    logic [CNT_W-1:0] count;
    logic             tc;
    logic             idle_like, accept;

    assign idle_like = (state == SEQ_IDLE) || (state == SEQ_DONE);
    assign accept    = idle_like && bus.start && (bus.prog_sel != 2'd3);

    seq_cycle_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state == SEQ_RUN),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEQ_IDLE;
            pc_load_q <= 1'b0;
            addr_q    <= '0;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            prog_id_q <= 2'd0;
        end else begin
            err_q <= 1'b0;
            case (state)
                SEQ_IDLE, SEQ_DONE: begin
                    if (accept) begin
                        state     <= SEQ_LOAD;
                        prog_id_q <= bus.prog_sel;
                        pc_load_q <= 1'b1;
                        addr_q    <= PC_W'(prog_start(bus.prog_sel));
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        timeout_q <= 1'b0;
                    end else if (bus.start) begin
                        err_q <= 1'b1;
                    end
                end
                SEQ_LOAD: begin
                    state     <= SEQ_RUN;
                    pc_load_q <= 1'b0;
                    addr_q    <= '0;
                    run_q     <= 1'b1;
                end
                SEQ_RUN: begin
                    // Halt takes priority over a coincident watchdog expiry.
                    if (bus.halt || tc) begin
                        state     <= SEQ_DONE;
                        run_q     <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        timeout_q <= !bus.halt;
                    end
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

    assign bus.pc_load      = pc_load_q;
    assign bus.pc_load_addr = addr_q;
    assign bus.run          = run_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.timeout      = timeout_q;
    assign bus.err          = err_q;
    assign bus.prog_id      = prog_id_q;
    assign bus.cycles       = count;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed checks of the run controller with a 20-cycle watchdog.
module tb_prog_sequencer;
    localparam int PC_W    = 8;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    prog_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    prog_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input logic [1:0] sel);
        bus.start    = 1'b1;
        bus.prog_sel = sel;
        step();
        bus.start    = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.prog_sel = 2'd0;
        bus.halt     = 1'b0;
        steps(2);
        check("rst_pc_load", 32'(bus.pc_load), 0);
        check("rst_run", 32'(bus.run), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_cycles", 32'(bus.cycles), 0);
        check("rst_prog_id", 32'(bus.prog_id), 0);
        reset = 1'b0;
        step();

        // Illegal select in IDLE: single err pulse, no load
        do_start(2'd3);
        check("ill_err", 32'(bus.err), 1);
        check("ill_pc_load", 32'(bus.pc_load), 0);
        check("ill_busy", 32'(bus.busy), 0);
        step();
        check("ill_err_drop", 32'(bus.err), 0);
        check("ill_still_idle", 32'(bus.busy), 0);

        // Test 1: PRODUCT, halt on 10th RUN cycle
        do_start(2'd0);
        check("t1_pc_load", 32'(bus.pc_load), 1);
        check("t1_addr", 32'(bus.pc_load_addr), 0);
        check("t1_run_load", 32'(bus.run), 0);
        check("t1_busy", 32'(bus.busy), 1);
        step();
        check("t1_pc_load_drop", 32'(bus.pc_load), 0);
        check("t1_run", 32'(bus.run), 1);
        steps(9);
        check("t1_cycles9", 32'(bus.cycles), 9);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t1_done", 32'(bus.done), 1);
        check("t1_cycles", 32'(bus.cycles), 10);
        check("t1_timeout", 32'(bus.timeout), 0);
        check("t1_prog_id", 32'(bus.prog_id), 0);
        check("t1_run_off", 32'(bus.run), 0);

        // Test 2: STRING MATCH then CLOSEST PAIR back-to-back
        do_start(2'd1);
        check("t2a_addr", 32'(bus.pc_load_addr), 25);
        check("t2a_cycles_clr", 32'(bus.cycles), 0);
        check("t2a_done_low", 32'(bus.done), 0);
        check("t2a_prog_id", 32'(bus.prog_id), 1);
        step();
        check("t2a_addr_off", 32'(bus.pc_load_addr), 0);
        check("t2a_done_run", 32'(bus.done), 0);
        steps(2);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t2a_cycles", 32'(bus.cycles), 3);
        check("t2a_done", 32'(bus.done), 1);
        do_start(2'd2);
        check("t2b_addr", 32'(bus.pc_load_addr), 44);
        check("t2b_cycles_clr", 32'(bus.cycles), 0);
        check("t2b_done_low", 32'(bus.done), 0);
        step();
        steps(4);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t2b_cycles", 32'(bus.cycles), 5);
        check("t2b_prog_id", 32'(bus.prog_id), 2);

        // Test 3: watchdog expiry, then halt exactly on cycle 20
        do_start(2'd0);
        step();
        steps(19);
        check("t3a_cycles19", 32'(bus.cycles), 19);
        check("t3a_run19", 32'(bus.run), 1);
        check("t3a_done19", 32'(bus.done), 0);
        step();
        check("t3a_done", 32'(bus.done), 1);
        check("t3a_timeout", 32'(bus.timeout), 1);
        check("t3a_cycles", 32'(bus.cycles), 20);
        check("t3a_run_off", 32'(bus.run), 0);
        step();
        check("t3a_cycles_held", 32'(bus.cycles), 20);
        do_start(2'd0);
        check("t3b_timeout_clr", 32'(bus.timeout), 0);
        step();
        steps(19);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t3b_done", 32'(bus.done), 1);
        check("t3b_timeout", 32'(bus.timeout), 0);
        check("t3b_cycles", 32'(bus.cycles), 20);

        // Test 4: illegal select from DONE keeps status; start in RUN ignored
        do_start(2'd3);
        check("t4_err", 32'(bus.err), 1);
        check("t4_done_kept", 32'(bus.done), 1);
        check("t4_cycles_kept", 32'(bus.cycles), 20);
        check("t4_no_load", 32'(bus.pc_load), 0);
        do_start(2'd1);
        check("t4_err_off", 32'(bus.err), 0);
        step();
        do_start(2'd2);
        check("t4_run_prog_id", 32'(bus.prog_id), 1);
        check("t4_run_no_load", 32'(bus.pc_load), 0);
        check("t4_run_no_err", 32'(bus.err), 0);
        check("t4_run_still", 32'(bus.run), 1);
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t4_cycles", 32'(bus.cycles), 2);

        // Test 5: halt on first RUN cycle with coincident start
        do_start(2'd2);
        step();
        bus.halt     = 1'b1;
        bus.start    = 1'b1;
        bus.prog_sel = 2'd0;
        step();
        bus.halt  = 1'b0;
        bus.start = 1'b0;
        check("t5_cycles", 32'(bus.cycles), 1);
        check("t5_done", 32'(bus.done), 1);
        check("t5_prog_id", 32'(bus.prog_id), 2);
        check("t5_no_load", 32'(bus.pc_load), 0);
        step();
        check("t5_done_held", 32'(bus.done), 1);
        check("t5_busy", 32'(bus.busy), 0);

        // Test 6: asynchronous reset mid-RUN
        do_start(2'd1);
        step();
        steps(3);
        #2;
        reset = 1'b1;
        #1;
        check("t6_run", 32'(bus.run), 0);
        check("t6_busy", 32'(bus.busy), 0);
        check("t6_cycles", 32'(bus.cycles), 0);
        check("t6_prog_id", 32'(bus.prog_id), 0);
        step();
        reset = 1'b0;
        step();
        check("t6_idle_done", 32'(bus.done), 0);
        do_start(2'd2);
        check("t6_addr", 32'(bus.pc_load_addr), 44);
        step();
        check("t6_run_on", 32'(bus.run), 1);
        step();
        bus.halt = 1'b1;
        step();
        bus.halt = 1'b0;
        check("t6_cycles_after", 32'(bus.cycles), 2);
        check("t6_done_after", 32'(bus.done), 1);
        check("t6_prog_id_after", 32'(bus.prog_id), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
